// File: rtl/bus_cycle_pkg.sv
// Shared types and constants for the 68000 bus-cycle controller.
//   state_t     : controller FSM states
//   ADDR_W      : CPU address width
//   *_DEF       : default parameter values for bus_cycle_control
//   TMO_W       : width of the ready-timeout counter
package bus_cycle_pkg;

    localparam int unsigned ADDR_W      = 24;
    localparam int unsigned NUM_CS_DEF  = 4;
    localparam int unsigned WAIT_W_DEF  = 4;
    localparam int unsigned TIMEOUT_DEF = 64;
    localparam int unsigned TMO_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_RDY,
        ST_STEP,
        ST_ACK,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/bus_cycle_control_sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus a rising-edge pulse.
//   clk    : destination clock
//   rst    : async active-high reset, clears all flops
//   din    : asynchronous input
//   level  : synchronised level (registered)
//   rise_c : one-cycle pulse on a synchronised rising edge (combinational)
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise_c
);

    logic meta;
    logic prev;

    // Synchroniser chain plus one history flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 1'b0;
            level <= 1'b0;
            prev  <= 1'b0;
        end else begin
            meta  <= din;
            level <= meta;
            prev  <= level;
        end
    end

    assign rise_c = level & ~prev;

endmodule

// File: rtl/bus_cycle_control.sv
// 68000 bus-cycle controller: decodes the address into one of NUM_CS
// chip-select regions, inserts wait states, optionally waits for an external
// ready or a single-step button, then answers with DTACK (or BERR).
//   CPUCLK_IN, RESET_IN            : clock, async active-high reset
//   AS_IN, WR_IN, UDS_IN, LDS_IN   : CPU strobes/direction (active-high)
//   ADDR_IN                        : CPU address
//   STEPEN_IN, STEP_IN             : single-step enable, async step button
//   RDY_IN                         : async ready from slow devices
//   CS_BASE_IN/MASK/WAIT/RO/EXT    : per-region configuration, region i at slice i
//   CS, OE, WE_U, WE_L, DTACK, BERR: registered active-high outputs
module bus_cycle_control
    import bus_cycle_pkg::*;
#(
    parameter int unsigned NUM_CS  = NUM_CS_DEF,
    parameter int unsigned WAIT_W  = WAIT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                       CPUCLK_IN,
    input  logic                       RESET_IN,
    input  logic                       AS_IN,
    input  logic                       WR_IN,
    input  logic                       UDS_IN,
    input  logic                       LDS_IN,
    input  logic [ADDR_W-1:0]          ADDR_IN,
    input  logic                       STEPEN_IN,
    input  logic                       STEP_IN,
    input  logic                       RDY_IN,
    input  logic [NUM_CS*ADDR_W-1:0]   CS_BASE_IN,
    input  logic [NUM_CS*ADDR_W-1:0]   CS_MASK_IN,
    input  logic [NUM_CS*WAIT_W-1:0]   CS_WAIT_IN,
    input  logic [NUM_CS-1:0]          CS_RO_IN,
    input  logic [NUM_CS-1:0]          CS_EXT_IN,
    output logic [NUM_CS-1:0]          CS,
    output logic                       OE,
    output logic                       WE_U,
    output logic                       WE_L,
    output logic                       DTACK,
    output logic                       BERR
);

    localparam int unsigned SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    state_t              state, state_next;
    logic [WAIT_W-1:0]   wcnt, wcnt_next;
    logic [TMO_W-1:0]    tmo, tmo_next;
    logic [SEL_W-1:0]    sel, sel_next;
    logic                ext, ext_next;
    logic                as_low;

    logic                hit, hit_ro, hit_ext;
    logic [SEL_W-1:0]    hit_idx;
    logic [WAIT_W-1:0]   hit_wait;

    logic                cs_act;
    logic [NUM_CS-1:0]   cs_next;
    logic                oe_next, we_u_next, we_l_next, dtack_next, berr_next;

    logic                rdy_lvl;
    logic                rdy_rise_unused;
    logic                step_lvl_unused;
    logic                step_rise;

    // Ready input only matters as a level; its edge pulse is left unused
    sync_edge u_sync_rdy (
        .clk    (CPUCLK_IN),
        .rst    (RESET_IN),
        .din    (RDY_IN),
        .level  (rdy_lvl),
        .rise_c (rdy_rise_unused)
    );

    // Step button only matters as a press (rising edge)
    sync_edge u_sync_step (
        .clk    (CPUCLK_IN),
        .rst    (RESET_IN),
        .din    (STEP_IN),
        .level  (step_lvl_unused),
        .rise_c (step_rise)
    );

    // Address decode: scan downwards so the lowest hitting region wins
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_ro   = 1'b0;
        hit_ext  = 1'b0;
        hit_wait = '0;
        for (int i = NUM_CS - 1; i >= 0; i--) begin
            if ((ADDR_IN & CS_MASK_IN[i*ADDR_W +: ADDR_W]) ==
                (CS_BASE_IN[i*ADDR_W +: ADDR_W] & CS_MASK_IN[i*ADDR_W +: ADDR_W])) begin
                hit      = 1'b1;
                hit_idx  = SEL_W'(i);
                hit_ro   = CS_RO_IN[i];
                hit_ext  = CS_EXT_IN[i];
                hit_wait = CS_WAIT_IN[i*WAIT_W +: WAIT_W];
            end
        end
    end

    // Next-state, datapath and next-output logic
    always_comb begin
        state_next = state;
        wcnt_next  = wcnt;
        tmo_next   = tmo;
        sel_next   = sel;
        ext_next   = ext;

        case (state)
            ST_IDLE: begin
                // Only a fresh low-to-high strobe starts a cycle
                if (AS_IN && as_low) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (!hit || (hit_ro && WR_IN)) begin
                    state_next = ST_ERROR;
                end else begin
                    sel_next   = hit_idx;
                    ext_next   = hit_ext;
                    wcnt_next  = hit_wait;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt == '0) begin
                    if (ext) begin
                        tmo_next   = '0;
                        state_next = ST_RDY;
                    end else if (STEPEN_IN) begin
                        state_next = ST_STEP;
                    end else begin
                        state_next = ST_ACK;
                    end
                end else begin
                    wcnt_next = wcnt - WAIT_W'(1);
                end
            end
            ST_RDY: begin
                if (rdy_lvl) begin
                    state_next = STEPEN_IN ? ST_STEP : ST_ACK;
                end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                    state_next = ST_ERROR;
                end else if (tmo != '1) begin
                    tmo_next = tmo + TMO_W'(1);
                end
            end
            ST_STEP: begin
                if (!STEPEN_IN || step_rise) state_next = ST_ACK;
            end
            ST_ACK, ST_ERROR: begin
                state_next = state;
            end
            default: state_next = ST_IDLE;
        endcase

        // Strobe withdrawal aborts any cycle in progress
        if (state != ST_IDLE && !AS_IN) state_next = ST_IDLE;

        cs_act     = (state_next == ST_WAIT) || (state_next == ST_RDY) ||
                     (state_next == ST_STEP) || (state_next == ST_ACK);
        cs_next    = cs_act ? (NUM_CS'(1) << sel_next) : '0;
        oe_next    = cs_act && !WR_IN;
        we_u_next  = cs_act && WR_IN && UDS_IN;
        we_l_next  = cs_act && WR_IN && LDS_IN;
        dtack_next = (state_next == ST_ACK);
        berr_next  = (state_next == ST_ERROR);
    end

    // State, datapath and output registers
    always_ff @(posedge CPUCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state  <= ST_IDLE;
            wcnt   <= '0;
            tmo    <= '0;
            sel    <= '0;
            ext    <= 1'b0;
            as_low <= 1'b0;
            CS     <= '0;
            OE     <= 1'b0;
            WE_U   <= 1'b0;
            WE_L   <= 1'b0;
            DTACK  <= 1'b0;
            BERR   <= 1'b0;
        end else begin
            state  <= state_next;
            wcnt   <= wcnt_next;
            tmo    <= tmo_next;
            sel    <= sel_next;
            ext    <= ext_next;
            as_low <= !AS_IN;
            CS     <= cs_next;
            OE     <= oe_next;
            WE_U   <= we_u_next;
            WE_L   <= we_l_next;
            DTACK  <= dtack_next;
            BERR   <= berr_next;
        end
    end

endmodule

// File: tb/tb_bus_cycle_control.sv
// Self-checking bench for bus_cycle_control: a table of single bus cycles
// plus hand-written sequences for ready timeout, single-step, abort and reset.
module tb_bus_cycle_control;
    import bus_cycle_pkg::*;

    localparam int unsigned NCS = 4;
    localparam int unsigned WW  = 4;

    logic clk = 1'b0;
    logic rst;
    logic as_in, wr_in, uds_in, lds_in;
    logic [ADDR_W-1:0] addr;
    logic stepen, step_in, rdy_in;
    logic [NCS*ADDR_W-1:0] cs_base, cs_mask;
    logic [NCS*WW-1:0] cs_wait;
    logic [NCS-1:0] cs_ro, cs_ext;
    logic [NCS-1:0] cs;
    logic oe, we_u, we_l, dtack, berr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Region map: r0 0x0xxxxx w0; r1 0x2xxxxx w5 RO; r2 0x4xxxxx EXT; r3 0x4-7xxxxx w2
    assign cs_base = {24'h400000, 24'h400000, 24'h200000, 24'h000000};
    assign cs_mask = {24'hC00000, 24'hF00000, 24'hF00000, 24'hF00000};
    assign cs_wait = {4'd2, 4'd0, 4'd5, 4'd0};
    assign cs_ro   = 4'b0010;
    assign cs_ext  = 4'b0100;

    bus_cycle_control #(.NUM_CS(NCS), .WAIT_W(WW), .TIMEOUT(64)) dut (
        .CPUCLK_IN  (clk),
        .RESET_IN   (rst),
        .AS_IN      (as_in),
        .WR_IN      (wr_in),
        .UDS_IN     (uds_in),
        .LDS_IN     (lds_in),
        .ADDR_IN    (addr),
        .STEPEN_IN  (stepen),
        .STEP_IN    (step_in),
        .RDY_IN     (rdy_in),
        .CS_BASE_IN (cs_base),
        .CS_MASK_IN (cs_mask),
        .CS_WAIT_IN (cs_wait),
        .CS_RO_IN   (cs_ro),
        .CS_EXT_IN  (cs_ext),
        .CS         (cs),
        .OE         (oe),
        .WE_U       (we_u),
        .WE_L       (we_l),
        .DTACK      (dtack),
        .BERR       (berr)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic              uds;
        logic              lds;
        logic [NCS-1:0]    cs;
        logic              oe;
        logic              we_u;
        logic              we_l;
        int                d_cyc;
        int                b_cyc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus-wide invariants on every falling edge outside reset
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("dtack_berr_excl", 32'(dtack & berr), 32'd0);
            chk("cs_onehot", 32'($countones(cs) > 1), 32'd0);
        end
    end

    // Step cycles 1..limit after the strobe was raised; records first DTACK/BERR cycle
    task automatic run_until(input int limit, input int rdy_at, input int step_at,
                             input int stepen_off_at, output int d_cyc, output int b_cyc,
                             output logic [NCS-1:0] cs2);
        d_cyc = 0;
        b_cyc = 0;
        cs2   = '0;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk); #1;
            if (k == 2) cs2 = cs;
            if (dtack && d_cyc == 0) d_cyc = k;
            if (berr && b_cyc == 0) b_cyc = k;
            if (k == rdy_at) rdy_in = 1'b1;
            if (k == step_at) step_in = 1'b1;
            if (k == step_at + 2) step_in = 1'b0;
            if (k == stepen_off_at) stepen = 1'b0;
            if (d_cyc != 0 || b_cyc != 0) break;
        end
    endtask

    // Drop the strobe; every output must be low one cycle later
    task automatic end_cycle(input string name);
        as_in = 1'b0;
        @(posedge clk); #1;
        chk(name, 32'({cs, oe, we_u, we_l, dtack, berr}), 32'd0);
    endtask

    task automatic start(input logic [ADDR_W-1:0] a, input logic wr, input logic u, input logic l);
        addr   = a;
        wr_in  = wr;
        uds_in = u;
        lds_in = l;
        as_in  = 1'b1;
    endtask

    int d, b;
    logic [NCS-1:0] c2;

    initial begin
        rst = 1'b1; as_in = 1'b0; wr_in = 1'b0; uds_in = 1'b0; lds_in = 1'b0;
        addr = '0; stepen = 1'b0; step_in = 1'b0; rdy_in = 1'b1;

        //                addr        wr uds lds cs       oe weu wel dtack berr
        vecs[0] = '{24'h000100, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 3, 0};
        vecs[1] = '{24'h012344, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 3, 0};
        vecs[2] = '{24'h200010, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 2};
        vecs[3] = '{24'h200010, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 8, 0};
        vecs[4] = '{24'hF00000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 2};
        vecs[5] = '{24'h400000, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 4, 0};
        vecs[6] = '{24'h500000, 1'b1, 1'b0, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b1, 5, 0};
        vecs[7] = '{24'h0FFFFE, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 3, 0};

        #1;
        chk("reset_outputs", 32'({cs, oe, we_u, we_l, dtack, berr}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Table-driven single cycles
        foreach (vecs[i]) begin
            start(vecs[i].addr, vecs[i].wr, vecs[i].uds, vecs[i].lds);
            run_until(40, 0, 0, 0, d, b, c2);
            chk($sformatf("v%0d_dtack_cyc", i), 32'(d), 32'(vecs[i].d_cyc));
            chk($sformatf("v%0d_berr_cyc", i), 32'(b), 32'(vecs[i].b_cyc));
            chk($sformatf("v%0d_cs_c2", i), 32'(c2), 32'(vecs[i].cs));
            chk($sformatf("v%0d_strobes", i), 32'({cs, oe, we_u, we_l}),
                32'({vecs[i].cs, vecs[i].oe, vecs[i].we_u, vecs[i].we_l}));
            @(posedge clk); #1;
            chk($sformatf("v%0d_hold", i), 32'({dtack, berr}),
                32'({vecs[i].d_cyc != 0, vecs[i].b_cyc != 0}));
            end_cycle($sformatf("v%0d_release", i));
        end

        // Ready never arrives: BERR after 64 cycles in RDY (entered at cycle 3)
        rdy_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start(24'h400000, 1'b0, 1'b1, 1'b1);
        run_until(100, 0, 0, 0, d, b, c2);
        chk("tmo_berr_cyc", 32'(b), 32'd67);
        chk("tmo_dtack_cyc", 32'(d), 32'd0);
        end_cycle("tmo_release");

        // Ready raised after cycle 10: two sync stages then ACK
        start(24'h400000, 1'b0, 1'b1, 1'b1);
        run_until(100, 10, 0, 0, d, b, c2);
        chk("rdy10_dtack_cyc", 32'(d), 32'd13);
        chk("rdy10_berr_cyc", 32'(b), 32'd0);
        end_cycle("rdy10_release");

        // Single-step: parks in STEP until the button press is synchronised
        stepen = 1'b1;
        start(24'h000100, 1'b0, 1'b1, 1'b1);
        run_until(30, 0, 8, 0, d, b, c2);
        chk("step_dtack_cyc", 32'(d), 32'd11);
        chk("step_cs_c2", 32'(c2), 32'b0001);
        end_cycle("step_release");

        // Step enable withdrawn while parked
        stepen = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start(24'h000100, 1'b0, 1'b1, 1'b1);
        run_until(30, 0, 0, 6, d, b, c2);
        chk("stepoff_dtack_cyc", 32'(d), 32'd7);
        end_cycle("stepoff_release");

        // Strobe withdrawn mid-WAIT
        start(24'h200010, 1'b0, 1'b1, 1'b1);
        run_until(4, 0, 0, 0, d, b, c2);
        chk("abort_no_ack", 32'({d != 0, b != 0}), 32'd0);
        chk("abort_cs_wait", 32'(cs), 32'b0010);
        end_cycle("abort_release");

        // Async reset during WAIT, strobe still high afterwards
        start(24'h200010, 1'b0, 1'b1, 1'b1);
        run_until(4, 0, 0, 0, d, b, c2);
        chk("rst_cs_before", 32'({cs, oe}), 32'b00101);
        #3 rst = 1'b1;
        #1 chk("rst_async_clear", 32'({cs, oe, we_u, we_l, dtack, berr}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        run_until(6, 0, 0, 0, d, b, c2);
        chk("rst_no_restart", 32'({d != 0, b != 0}), 32'd0);
        chk("rst_no_cs", 32'({c2, cs}), 32'd0);
        end_cycle("rst_as_low");
        start(24'h200010, 1'b0, 1'b1, 1'b1);
        run_until(20, 0, 0, 0, d, b, c2);
        chk("rst_retry_dtack_cyc", 32'(d), 32'd8);
        chk("rst_retry_cs_c2", 32'(c2), 32'b0010);
        end_cycle("rst_retry_release");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
